// File: rtl/wb_commit_queue_if.sv
// ============================================================================
// Module     : wb_commit_queue_if
// Description: EXU-side push, IFU-side next-PC and architectural write-port
//              bundle of the write-back/commit queue.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_commit_queue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_npc_sel;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_csr_rdata;
  logic            in_regw;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_wdata;
  logic            in_csrw;
  logic [11:0]     in_csr_addr;
  logic [XLEN-1:0] in_csr_wdata;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_npc;
  logic [XLEN-1:0] pc;

  logic            reg_wen;
  logic [4:0]      reg_waddr;
  logic [XLEN-1:0] reg_wdata;
  logic            csr_wen;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic [63:0]     perf_commit_cnt;

  // Commit-queue view
  modport slave (
    input  in_valid, in_npc_sel, in_imm, in_rs1, in_csr_rdata, in_regw, in_rd,
           in_wdata, in_csrw, in_csr_addr, in_csr_wdata, out_ready,
    output in_ready, out_valid, out_npc, pc, reg_wen, reg_waddr, reg_wdata,
           csr_wen, csr_waddr, csr_wdata, perf_commit_cnt
  );

  // EXU/IFU/register-file view
  modport master (
    output in_valid, in_npc_sel, in_imm, in_rs1, in_csr_rdata, in_regw, in_rd,
           in_wdata, in_csrw, in_csr_addr, in_csr_wdata, out_ready,
    input  in_ready, out_valid, out_npc, pc, reg_wen, reg_waddr, reg_wdata,
           csr_wen, csr_waddr, csr_wdata, perf_commit_cnt
  );
endinterface

`default_nettype wire

// File: rtl/wb_commit_queue.sv
// ============================================================================
// Module     : wb_commit_queue
// Description: In-order write-back/commit FIFO between EXU and IFU; updates
//              the architectural PC and pulses GPR/CSR writes on each commit.
//              Optional macro WB_COMMIT_PERF_EN builds the commit counter.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_commit_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  wb_commit_queue_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0]      npc_sel;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] csr_rdata;
    logic            regw;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
    logic            csrw;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  entry_t          tail_entry;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [XLEN-1:0] pc_q;
  state_t          state;
  state_t          state_next;

  logic            full;
  logic            empty;
  logic            push;
  logic            commit;
  logic            out_valid;
  logic [XLEN-1:0] out_npc;
  logic [XLEN-1:0] head_npc;
  logic [XLEN-1:0] jalr_sum;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // No bypass: a full queue refuses even while a commit frees a slot.
  assign push  = bus.in_valid && !full;
  assign head  = mem[rd_ptr];

  assign tail_entry = '{
    npc_sel:   bus.in_npc_sel,
    imm:       bus.in_imm,
    rs1:       bus.in_rs1,
    csr_rdata: bus.in_csr_rdata,
    regw:      bus.in_regw,
    rd:        bus.in_rd,
    wdata:     bus.in_wdata,
    csrw:      bus.in_csrw,
    csr_addr:  bus.in_csr_addr,
    csr_wdata: bus.in_csr_wdata
  };

  assign jalr_sum = head.rs1 + head.imm;

  always_comb begin
    head_npc = pc_q + XLEN'(4);
    case (head.npc_sel)
      2'b00:   head_npc = pc_q + XLEN'(4);
      2'b01:   head_npc = pc_q + head.imm;
      2'b10:   head_npc = {jalr_sum[XLEN-1:1], 1'b0};
      default: head_npc = head.csr_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    out_npc    = RESET_PC;
    commit     = 1'b0;
    case (state)
      ST_BOOT: begin
        out_valid = 1'b1;
        out_npc   = RESET_PC;
        if (bus.out_ready) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        out_valid = !empty;
        out_npc   = head_npc;
        // Gated by rst so a pending reset never leaks a write.
        commit    = !empty && bus.out_ready && !rst;
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_BOOT;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pc_q   <= RESET_PC;
    end else begin
      state <= state_next;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (commit) begin
        rd_ptr <= rd_ptr + AW'(1);
        pc_q   <= out_npc;
      end
      case ({push, commit})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= tail_entry;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = out_valid;
  assign bus.out_npc   = out_npc;
  assign bus.pc        = pc_q;
  assign bus.reg_wen   = commit && head.regw && (head.rd != 5'd0);
  assign bus.reg_waddr = head.rd;
  assign bus.reg_wdata = head.wdata;
  assign bus.csr_wen   = commit && head.csrw;
  assign bus.csr_waddr = head.csr_addr;
  assign bus.csr_wdata = head.csr_wdata;

`ifdef WB_COMMIT_PERF_EN
  logic [63:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (commit) begin
      perf_q <= perf_q + 64'd1;
    end
  end

  assign bus.perf_commit_cnt = perf_q;
`else
  assign bus.perf_commit_cnt = 64'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_commit_queue.sv
// ============================================================================
// Module     : tb_wb_commit_queue
// Description: Randomised scoreboard bench for wb_commit_queue (honours
//              WB_COMMIT_PERF_EN when defined).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_commit_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct {
    logic [31:0] npc;
    logic        reg_wen;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        csr_wen;
    logic [11:0] caddr;
    logic [31:0] cwdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_commit_queue_if #(.XLEN(XLEN)) bus ();

  wb_commit_queue #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Scoreboard state
  exp_t        exp_q[$];
  logic [31:0] tail_pc = RESET_PC;
  logic        rst_q   = 1'b0;
  int          rd_idx  = 0;
  logic [31:0] arch_pc = RESET_PC;
  logic        boot    = 1'b1;
  longint      commits = 0;
  int          checks  = 0;
  int          failures = 0;
  logic        end_req  = 1'b0;
  logic        mon_done = 1'b0;

  // Capture accepted pushes; expected next-PC chains from the previous push.
  always @(posedge clk) begin
    exp_t        e;
    logic [31:0] sum;
    rst_q <= rst;
    if (rst) begin
      tail_pc <= RESET_PC;
    end else if (bus.in_valid && bus.in_ready) begin
      case (bus.in_npc_sel)
        2'b00: e.npc = tail_pc + 32'd4;
        2'b01: e.npc = tail_pc + bus.in_imm;
        2'b10: begin
          sum   = bus.in_rs1 + bus.in_imm;
          e.npc = sum & 32'hFFFF_FFFE;
        end
        default: e.npc = bus.in_csr_rdata;
      endcase
      e.reg_wen = bus.in_regw && (bus.in_rd != 5'd0);
      e.rd      = bus.in_rd;
      e.wdata   = bus.in_wdata;
      e.csr_wen = bus.in_csrw;
      e.caddr   = bus.in_csr_addr;
      e.cwdata  = bus.in_csr_wdata;
      exp_q.push_back(e);
      tail_pc <= e.npc;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: compares DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    int     occ;
    exp_t   e;
    longint perf_exp;
    if (rst) begin
      chk("rst_reg_wen", 64'(bus.reg_wen), 64'd0);
      chk("rst_csr_wen", 64'(bus.csr_wen), 64'd0);
      if (rst_q) begin
        chk("rst_out_valid", 64'(bus.out_valid), 64'd1);
        chk("rst_out_npc", 64'(bus.out_npc), 64'(RESET_PC));
        chk("rst_pc", 64'(bus.pc), 64'(RESET_PC));
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_perf", bus.perf_commit_cnt, 64'd0);
      end
      boot    = 1'b1;
      arch_pc = RESET_PC;
      rd_idx  = exp_q.size();
      commits = 0;
    end else begin
      occ = exp_q.size() - rd_idx;
`ifdef WB_COMMIT_PERF_EN
      perf_exp = commits;
`else
      perf_exp = 0;
`endif
      chk("in_ready", 64'(bus.in_ready), 64'(occ < DEPTH));
      chk("pc", 64'(bus.pc), 64'(arch_pc));
      chk("perf_cnt", bus.perf_commit_cnt, 64'(perf_exp));
      if (boot) begin
        chk("boot_out_valid", 64'(bus.out_valid), 64'd1);
        chk("boot_out_npc", 64'(bus.out_npc), 64'(RESET_PC));
        chk("boot_reg_wen", 64'(bus.reg_wen), 64'd0);
        chk("boot_csr_wen", 64'(bus.csr_wen), 64'd0);
        if (bus.out_ready) boot = 1'b0;
      end else begin
        chk("out_valid", 64'(bus.out_valid), 64'(occ > 0));
        if (occ > 0) begin
          e = exp_q[rd_idx];
          chk("out_npc", 64'(bus.out_npc), 64'(e.npc));
          if (bus.out_ready) begin
            chk("reg_wen", 64'(bus.reg_wen), 64'(e.reg_wen));
            chk("csr_wen", 64'(bus.csr_wen), 64'(e.csr_wen));
            if (e.reg_wen) begin
              chk("reg_waddr", 64'(bus.reg_waddr), 64'(e.rd));
              chk("reg_wdata", 64'(bus.reg_wdata), 64'(e.wdata));
            end
            if (e.csr_wen) begin
              chk("csr_waddr", 64'(bus.csr_waddr), 64'(e.caddr));
              chk("csr_wdata", 64'(bus.csr_wdata), 64'(e.cwdata));
            end
            rd_idx++;
            arch_pc = e.npc;
            commits++;
          end else begin
            chk("stall_reg_wen", 64'(bus.reg_wen), 64'd0);
            chk("stall_csr_wen", 64'(bus.csr_wen), 64'd0);
          end
        end else begin
          chk("empty_reg_wen", 64'(bus.reg_wen), 64'd0);
          chk("empty_csr_wen", 64'(bus.csr_wen), 64'd0);
        end
      end
      if (end_req && !mon_done) begin
        chk("drained", 64'(exp_q.size() - rd_idx), 64'd0);
        chk("commits_seen", 64'(commits > 0), 64'd1);
        mon_done = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [1:0] sel, input logic [31:0] imm, input logic [31:0] rs1,
                      input logic [31:0] csr, input logic regw, input logic [4:0] rd,
                      input logic [31:0] wdata, input logic csrw, input logic [11:0] caddr,
                      input logic [31:0] cwdata);
    bus.in_valid     = 1'b1;
    bus.in_npc_sel   = sel;
    bus.in_imm       = imm;
    bus.in_rs1       = rs1;
    bus.in_csr_rdata = csr;
    bus.in_regw      = regw;
    bus.in_rd        = rd;
    bus.in_wdata     = wdata;
    bus.in_csrw      = csrw;
    bus.in_csr_addr  = caddr;
    bus.in_csr_wdata = cwdata;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic push_rand();
    push(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
         1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
         1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), $urandom);
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_npc_sel   = 2'b00;
    bus.in_imm       = '0;
    bus.in_rs1       = '0;
    bus.in_csr_rdata = '0;
    bus.in_regw      = 1'b0;
    bus.in_rd        = '0;
    bus.in_wdata     = '0;
    bus.in_csrw      = 1'b0;
    bus.in_csr_addr  = '0;
    bus.in_csr_wdata = '0;
    bus.out_ready    = 1'b1;
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    idle(3);

    // Directed next-PC modes, writes and rd==0 suppression
    push(2'b00, 32'd0, 32'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 1'b0, 12'h0, 32'h0);
    idle(2);
    push(2'b10, 32'd4, 32'h8000_1001, 32'd0, 1'b0, 5'd0, 32'h0, 1'b0, 12'h0, 32'h0);
    push(2'b11, 32'd0, 32'd0, 32'h8000_0100, 1'b0, 5'd0, 32'h0, 1'b1, 12'h305, 32'h55AA);
    push(2'b01, 32'h20, 32'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 12'h0, 32'h0);
    push(2'b01, 32'hFFFF_FFF0, 32'd0, 32'd0, 1'b1, 5'd31, 32'hBEEF, 1'b0, 12'h0, 32'h0);
    idle(3);

    // Fill: five offers with IFU stalled, only DEPTH land
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_rand();
    idle(2);
    bus.out_ready = 1'b1;
    idle(6);

    // Random traffic with random IFU back-pressure
    for (int i = 0; i < 300; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) push_rand();
      else idle(1);
    end
    bus.out_ready = 1'b1;
    idle(10);

    // Reset with three entries queued
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_rand();
    idle(1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    idle(2);
    for (int i = 0; i < 12; i++) push_rand();
    idle(10);

    end_req = 1'b1;
    for (int i = 0; i < 5 && !mon_done; i++) tick();
    if (!mon_done) $display("FAIL end_check: monitor did not finish, expected done");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + (mon_done ? 0 : 1));
    $finish;
  end

endmodule

`default_nettype wire
